// File: rtl/conv_s2_scheduler.sv
// conv_s2_scheduler: stage-2 conv MAC sequencer (filters x channels per window, raster order); CONV_S2_PERF_EN adds perf_cycles
module conv_s2_scheduler #(
  parameter int OUT_W = 4,
  parameter int OUT_H = 4,
  parameter int NUM_FILT = 4,
  parameter int NUM_CH = 3,
  localparam int FW = NUM_FILT > 1 ? $clog2(NUM_FILT) : 1,
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int RW = OUT_H > 1 ? $clog2(OUT_H) : 1,
  localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  input  logic           win_valid,
  output logic           win_ready,
  output logic [FW-1:0]  filt_sel,
  output logic [CHW-1:0] ch_sel,
  output logic           mac_en,
  output logic           mac_clr,
  output logic           mac_last,
  input  logic           mac_valid,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [FW-1:0]  res_filt,
  output logic [RW-1:0]  res_row,
  output logic [CW-1:0]  res_col
`ifdef CONV_S2_PERF_EN
  ,
  output logic [31:0]    perf_cycles
`endif
);
  typedef enum logic [2:0] {IDLE, WAIT_WIN, ISSUE, WAIT_MAC, RESULT, ADV} state_t;
  state_t state, state_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] col, col_n;
  logic [FW-1:0] filt, filt_n;
  logic [CHW-1:0] ch, ch_n;
  logic last_row, last_col, last_filt, last_ch;
  assign last_row = row == RW'(OUT_H - 1);
  assign last_col = col == CW'(OUT_W - 1);
  assign last_filt = filt == FW'(NUM_FILT - 1);
  assign last_ch = ch == CHW'(NUM_CH - 1);
  // state and position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      filt <= '0;
      ch <= '0;
    end else begin
      state <= state_n;
      row <= row_n;
      col <= col_n;
      filt <= filt_n;
      ch <= ch_n;
    end
  end
  // next state; the window is held for all filters and released in ADV
  always_comb begin
    state_n = state;
    row_n = row;
    col_n = col;
    filt_n = filt;
    ch_n = ch;
    case (state)
      IDLE: if (start) begin
        state_n = WAIT_WIN;
        row_n = '0;
        col_n = '0;
        filt_n = '0;
        ch_n = '0;
      end
      WAIT_WIN: state_n = win_valid ? ISSUE : WAIT_WIN;
      ISSUE: begin
        state_n = last_ch ? WAIT_MAC : ISSUE;
        ch_n = last_ch ? ch : ch + 1'b1;
      end
      WAIT_MAC: state_n = mac_valid ? RESULT : WAIT_MAC;
      RESULT: if (res_ready) begin
        ch_n = '0;
        state_n = last_filt ? ADV : ISSUE;
        filt_n = last_filt ? filt : filt + 1'b1;
      end
      ADV: begin
        filt_n = '0;
        col_n = last_col ? '0 : col + 1'b1;
        row_n = last_col ? (last_row ? '0 : row + 1'b1) : row;
        state_n = (last_row && last_col) ? IDLE : WAIT_WIN;
      end
      default: state_n = IDLE;
    endcase
  end
  assign done = state == ADV && last_row && last_col;
  assign busy = state != IDLE && !done;
  assign win_ready = state == ADV;
  assign mac_en = state == ISSUE;
  assign mac_clr = mac_en && ch == '0;
  assign mac_last = mac_en && last_ch;
  assign res_valid = state == RESULT;
  assign filt_sel = filt;
  assign ch_sel = ch;
  assign res_filt = filt;
  assign res_row = row;
  assign res_col = col;
`ifdef CONV_S2_PERF_EN
  // busy-cycle counter, cleared on accepted start, saturating
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start))
      perf_cycles <= '0;
    else if (busy && perf_cycles != '1)
      perf_cycles <= perf_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_conv_s2_scheduler.sv
// tb_conv_s2_scheduler: randomized scoreboard bench for conv_s2_scheduler
module tb_conv_s2_scheduler;
  localparam int OW = 2, OH = 2, NF = 4, NC = 3, NW = OW * OH;
  logic clk = 0, rst, start, win_valid, mac_valid, res_ready;
  logic busy, done, win_ready, mac_en, mac_clr, mac_last, res_valid;
  logic [1:0] filt_sel, ch_sel, res_filt;
  logic [0:0] res_row, res_col;
`ifdef CONV_S2_PERF_EN
  logic [31:0] perf_cycles;
`endif
  conv_s2_scheduler #(.OUT_W(OW), .OUT_H(OH), .NUM_FILT(NF), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .win_valid(win_valid), .win_ready(win_ready), .filt_sel(filt_sel), .ch_sel(ch_sel),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last), .mac_valid(mac_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_filt(res_filt),
    .res_row(res_row), .res_col(res_col)
`ifdef CONV_S2_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int q[$];
  int cyc = 0, ch_e, in_win, win_cnt, n_mac, n_wr, n_done, n_res, mcnt, pending, wv_age, bp_left;
  int s_cyc, d_cyc;
  int lat_lo, lat_hi, rdy_pct, gap_max;
  bit spur, bp_test, wv_test, rst_test;
  bit active, waiting_res, mac_done, win_up, chk_age, last_seen, rst_hit, bp_done;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int tagof(input int r, input int c, input int f);
    return r * 256 + c * 16 + f;
  endfunction
  task automatic chk_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_win_ready", win_ready, 0);
    chk("rst_mac", {mac_en, mac_clr, mac_last}, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_sel", {filt_sel, ch_sel}, 0);
    chk("rst_tag", tagof(res_row, res_col, res_filt), 0);
`ifdef CONV_S2_PERF_EN
    chk("rst_perf", perf_cycles, 0);
`endif
  endtask
  // one clock cycle: observe outputs, check against the model, drive inputs, update the model
  task automatic step();
    int t, g;
    cyc++;
    if (win_valid) wv_age++;
    last_seen = 0;
    if (active) chk("busy", busy, !done);
    if (mac_en) begin
      if (q.size() == 0) chk("mac_extra", 1, 0);
      else begin
        t = q[0];
        if (in_win == 0 && ch_e == 0) begin
          chk("mac_win", win_up, 1);
          if (chk_age) begin
            chk("issue_lat", wv_age, 1);
            chk_age = 0;
          end
        end
        chk("mac_wait", waiting_res, 0);
        chk("filt_sel", filt_sel, t % 16);
        chk("ch_sel", ch_sel, ch_e);
        chk("mac_clr", mac_clr, ch_e == 0);
        chk("mac_last", mac_last, ch_e == NC - 1);
        if (rst_test && !rst_hit && t == tagof(1, 0, 1)) rst_hit = 1;
      end
      n_mac++;
      if (ch_e == NC - 1) begin
        ch_e = 0;
        waiting_res = 1;
        last_seen = 1;
      end else ch_e++;
    end else chk("mac_idle", {mac_clr, mac_last}, 0);
    if (res_valid) begin
      chk("res_tag", tagof(res_row, res_col, res_filt), q.size() > 0 ? q[0] : -1);
      chk("res_mac", mac_done, 1);
      chk("res_excl", {mac_en, win_ready}, 0);
    end
    if (win_ready) begin
      chk("win_filters", in_win, NF);
      in_win = 0;
      win_cnt++;
      n_wr++;
    end
    if (done) begin
      chk("done_wins", win_cnt, NW);
      chk("done_win_ready", win_ready, 1);
      chk("done_q", q.size(), 0);
      n_done++;
    end
    rst = rst_hit;
    start = active && spur && $urandom_range(0, 7) == 0;
    if (mcnt > 0) begin
      mcnt--;
      mac_valid = mcnt == 0;
      if (mac_valid) mac_done = 1;
    end else mac_valid = spur && (mac_en || res_valid) && $urandom_range(0, 1) == 1;
    if (last_seen) mcnt = $urandom_range(lat_lo, lat_hi);
    if (bp_test && !bp_done && res_valid && q.size() > 0 && q[0] == tagof(0, 0, 2)) begin
      res_ready = bp_left == 0;
      if (bp_left == 0) bp_done = 1;
      else bp_left--;
    end else res_ready = $urandom_range(0, 99) < rdy_pct;
    if (res_valid && res_ready) begin
      if (q.size() > 0) void'(q.pop_front());
      in_win++;
      waiting_res = 0;
      mac_done = 0;
      n_res++;
    end
    if (win_ready) begin
      g = (wv_test && win_cnt == 1) ? 10 : $urandom_range(0, gap_max);
      pending = g;
      win_up = g == 0;
    end else if (pending > 0 && win_valid) begin
      win_valid = 0;
      pending--;
    end else if (!win_valid) begin
      if (pending == 0) begin
        win_valid = 1;
        wv_age = 0;
        win_up = 1;
        chk_age = 1;
      end else pending--;
    end
    if (done) active = 0;
  endtask
  task automatic run_pass();
    q.delete();
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        for (int f = 0; f < NF; f++) q.push_back(tagof(r, c, f));
    {ch_e, in_win, win_cnt, n_mac, n_wr, n_done, n_res, mcnt, pending, wv_age} = '0;
    {waiting_res, mac_done, chk_age, rst_hit, bp_done} = '0;
    win_up = 1;
    bp_left = 5;
    @(negedge clk);
    cyc++;
    start = 1;
    win_valid = 1;
    mac_valid = 0;
    res_ready = 1;
    active = 1;
    s_cyc = cyc;
    for (int i = 0; i < 3000 && active && !rst_hit; i++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    cyc++;
    start = 0;
    mac_valid = 0;
    if (rst_hit) begin
      chk_reset();
      rst = 0;
      active = 0;
    end else if (active) begin
      chk("timeout", 0, 1);
      active = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
    end else begin
      d_cyc = cyc - 1;
`ifdef CONV_S2_PERF_EN
      chk("perf", perf_cycles, d_cyc - s_cyc - 1);
      repeat (5) @(negedge clk);
      chk("perf_hold", perf_cycles, d_cyc - s_cyc - 1);
`endif
    end
  endtask
  initial begin
    rst = 1;
    {start, win_valid, mac_valid, res_ready} = '0;
    {spur, bp_test, wv_test, rst_test} = '0;
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 0;
    lat_lo = 2; lat_hi = 2; rdy_pct = 100; gap_max = 0;
    run_pass();
    chk("p1_results", n_res, NW * NF);
    chk("p1_mac_en", n_mac, NW * NF * NC);
    chk("p1_win_ready", n_wr, NW);
    chk("p1_done", n_done, 1);
    chk("p1_cycles", d_cyc - s_cyc, NW * (2 + NF * (NC + 2 + 1)));
    lat_lo = 1; lat_hi = 3; bp_test = 1; wv_test = 1;
    run_pass();
    chk("bp_seen", bp_done, 1);
    chk("p2_results", n_res, NW * NF);
    bp_test = 0; wv_test = 0;
    lat_lo = 1; lat_hi = 4; rdy_pct = 60; gap_max = 3; spur = 1;
    repeat (3) begin
      run_pass();
      chk("rand_results", n_res, NW * NF);
      chk("rand_done", n_done, 1);
    end
    spur = 0; rdy_pct = 100; gap_max = 0; lat_lo = 2; lat_hi = 2; rst_test = 1;
    run_pass();
    chk("rst_hit", rst_hit, 1);
    chk("rst_no_done", n_done, 0);
    rst_test = 0;
    run_pass();
    chk("after_rst_results", n_res, NW * NF);
    chk("after_rst_done", n_done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
